// File: rtl/prt_ingress_writer_if.sv
// Bundle of the ingress byte stream, PRT write port and descriptor handshake of the PRT writer.
// master is the writer's view; slave is the view of the surrounding MAC/PRT/classifier.
interface prt_ingress_writer_if #(
  parameter int unsigned INDEX_SIZE = 2,
  parameter int unsigned LEN_W      = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [7:0]            s_data;
  logic                  s_last;
  logic                  prt_start_req;
  logic                  prt_start_gnt;
  logic [INDEX_SIZE-1:0] prt_slot;
  logic                  prt_wr_en;
  logic [7:0]            prt_wr_data;
  logic                  prt_finish;
  logic                  prt_invalidate;
  logic [INDEX_SIZE-1:0] prt_inv_slot;
  logic                  desc_valid;
  logic                  desc_ready;
  logic [INDEX_SIZE-1:0] desc_slot;
  logic [LEN_W-1:0]      desc_len;
  logic [15:0]           desc_ethertype;

  modport master (
    input  s_valid, s_data, s_last, prt_start_gnt, prt_slot, desc_ready,
    output s_ready, prt_start_req, prt_wr_en, prt_wr_data, prt_finish, prt_invalidate,
           prt_inv_slot, desc_valid, desc_slot, desc_len, desc_ethertype
  );

  modport slave (
    output s_valid, s_data, s_last, prt_start_gnt, prt_slot, desc_ready,
    input  s_ready, prt_start_req, prt_wr_en, prt_wr_data, prt_finish, prt_invalidate,
           prt_inv_slot, desc_valid, desc_slot, desc_len, desc_ethertype
  );
endinterface

// File: rtl/prt_ingress_writer.sv
// Writes one ingress frame into an allocated PRT slot, then issues or invalidates its descriptor.
// Define PRT_INGRESS_STATS_EN to add saturating ok/runt/oversize frame counters.
module prt_ingress_writer #(
  parameter int unsigned INDEX_SIZE = 2,
  parameter int unsigned MAX_FRAME  = 1520,
  parameter int unsigned MIN_FRAME  = 14,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  prt_ingress_writer_if.master  bus
`ifdef PRT_INGRESS_STATS_EN
  ,
  output logic [31:0]           stat_ok,
  output logic [31:0]           stat_runt,
  output logic [31:0]           stat_oversize
`endif
);

  typedef enum logic [2:0] {StIdle, StAlloc, StStream, StDrop, StFinish, StDesc, StInval} state_e;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [INDEX_SIZE-1:0] slot_q, slot_d;
  logic [15:0]           eth_q, eth_d;
  logic                  ovf_q, ovf_d;

  logic             ready, req, wr_en, finish, inval, dvalid;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    eth_d   = eth_q;
    ovf_d   = ovf_q;
    ready   = 1'b0;
    req     = 1'b0;
    wr_en   = 1'b0;
    finish  = 1'b0;
    inval   = 1'b0;
    dvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The pending byte stays upstream until a slot is granted.
        if (bus.s_valid) state_d = StAlloc;
      end
      StAlloc: begin
        req = 1'b1;
        if (bus.prt_start_gnt) begin
          slot_d  = bus.prt_slot;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StStream;
        end
      end
      StStream: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          if (cnt_q == LEN_W'(MAX_FRAME)) begin
            ovf_d   = 1'b1;
            state_d = bus.s_last ? StInval : StDrop;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_q == LEN_W'(12)) eth_d[15:8] = bus.s_data;
            if (cnt_q == LEN_W'(13)) eth_d[7:0]  = bus.s_data;
            if (bus.s_last) state_d = (cnt_inc >= LEN_W'(MIN_FRAME)) ? StFinish : StInval;
          end
        end
      end
      StDrop: begin
        ready = 1'b1;
        if (bus.s_valid && bus.s_last) state_d = StInval;
      end
      StFinish: begin
        finish  = 1'b1;
        state_d = StDesc;
      end
      StDesc: begin
        dvalid = 1'b1;
        if (bus.desc_ready) state_d = StIdle;
      end
      StInval: begin
        inval   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      slot_q  <= '0;
      eth_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      eth_q   <= eth_d;
      ovf_q   <= ovf_d;
    end
  end

  // Data-carrying outputs are held at zero whenever their qualifier is low.
  assign bus.s_ready        = ready;
  assign bus.prt_start_req  = req;
  assign bus.prt_wr_en      = wr_en;
  assign bus.prt_wr_data    = wr_en ? bus.s_data : 8'h00;
  assign bus.prt_finish     = finish;
  assign bus.prt_invalidate = inval;
  assign bus.prt_inv_slot   = inval ? slot_q : '0;
  assign bus.desc_valid     = dvalid;
  assign bus.desc_slot      = dvalid ? slot_q : '0;
  assign bus.desc_len       = dvalid ? cnt_q : '0;
  assign bus.desc_ethertype = dvalid ? eth_q : 16'h0000;

`ifdef PRT_INGRESS_STATS_EN
  logic [31:0] ok_q, runt_q, over_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_q   <= '0;
      runt_q <= '0;
      over_q <= '0;
    end else begin
      if (state_q == StFinish && ok_q != '1) ok_q <= ok_q + 1'b1;
      if (state_q == StInval && !ovf_q && runt_q != '1) runt_q <= runt_q + 1'b1;
      if (state_q == StInval && ovf_q && over_q != '1) over_q <= over_q + 1'b1;
    end
  end

  assign stat_ok       = ok_q;
  assign stat_runt     = runt_q;
  assign stat_oversize = over_q;
`endif

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Directed and randomized frames against a frame-level model of the PRT ingress writer.
module tb_prt_ingress_writer;
  localparam int unsigned INDEX_SIZE = 2;
  localparam int unsigned LEN_W      = 16;
  localparam int          MAX_FRAME  = 1520;
  localparam int          MIN_FRAME  = 14;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  prt_ingress_writer_if #(.INDEX_SIZE(INDEX_SIZE), .LEN_W(LEN_W)) bus ();

`ifdef PRT_INGRESS_STATS_EN
  logic [31:0] stat_ok, stat_runt, stat_oversize;
`endif

  prt_ingress_writer #(
    .INDEX_SIZE(INDEX_SIZE),
    .MAX_FRAME (MAX_FRAME),
    .MIN_FRAME (MIN_FRAME),
    .LEN_W     (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef PRT_INGRESS_STATS_EN
    ,
    .stat_ok      (stat_ok),
    .stat_runt    (stat_runt),
    .stat_oversize(stat_oversize)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint outs();
    return longint'({bus.s_ready, bus.prt_start_req, bus.prt_wr_en, bus.prt_wr_data,
                     bus.prt_finish, bus.prt_invalidate, bus.prt_inv_slot, bus.desc_valid,
                     bus.desc_slot, bus.desc_len, bus.desc_ethertype});
  endfunction

  // PRT allocator and classifier stand-ins, driven 1 ns after each rising edge.
  int gnt_delay = 0;
  int desc_delay = 0;
  logic [INDEX_SIZE-1:0] gnt_slot = '0;
  int req_cyc = 0;
  int dv_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      bus.prt_start_gnt = 1'b0;
      bus.prt_slot      = '0;
      bus.desc_ready    = 1'b0;
      req_cyc = 0;
      dv_cyc  = 0;
    end else begin
      if (bus.prt_start_req) begin
        bus.prt_start_gnt = (req_cyc >= gnt_delay);
        bus.prt_slot      = gnt_slot;
        req_cyc++;
      end else begin
        bus.prt_start_gnt = 1'b0;
        req_cyc = 0;
      end
      if (bus.desc_valid) begin
        bus.desc_ready = (dv_cyc >= desc_delay);
        dv_cyc++;
      end else begin
        bus.desc_ready = 1'b0;
        dv_cyc = 0;
      end
    end
  end

  // Monitor: samples mid-cycle, records everything as monotonic counters/logs.
  logic [7:0] wr_q[$];
  int cyc = 0, n_beats = 0, n_fin = 0, n_inv = 0, n_desc = 0, n_dvcyc = 0, n_req = 0;
  int n_viol = 0, n_unstable = 0;
  int last_cyc = 0, fin_cyc = 0, inv_cyc = 0, dv_first_cyc = 0;
  logic beat_flag = 1'b0;
  logic dv_prev = 1'b0;
  logic [INDEX_SIZE-1:0] inv_slot_seen = '0, d_slot = '0;
  logic [LEN_W-1:0] d_len = '0;
  logic [15:0] d_eth = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (bus.prt_wr_en) wr_q.push_back(bus.prt_wr_data);
      beat_flag = bus.s_valid && bus.s_ready;
      if (beat_flag) begin
        n_beats++;
        if (bus.s_last) last_cyc = cyc;
      end
      if (bus.prt_finish) begin
        n_fin++;
        fin_cyc = cyc;
      end
      if (bus.prt_invalidate) begin
        n_inv++;
        inv_slot_seen = bus.prt_inv_slot;
        inv_cyc = cyc;
      end
      if (bus.prt_start_req) begin
        n_req++;
        if (bus.s_ready) n_viol++;
      end
      if (bus.desc_valid) begin
        n_dvcyc++;
        if (!dv_prev) begin
          dv_first_cyc = cyc;
          d_slot = bus.desc_slot;
          d_len  = bus.desc_len;
          d_eth  = bus.desc_ethertype;
        end else if ({bus.desc_slot, bus.desc_len, bus.desc_ethertype} != {d_slot, d_len, d_eth}) begin
          n_unstable++;
        end
        if (bus.s_ready) n_viol++;
        if (bus.desc_ready) n_desc++;
      end
      dv_prev = bus.desc_valid;
    end else begin
      beat_flag = 1'b0;
      dv_prev   = 1'b0;
    end
  end

  int exp_ok = 0, exp_runt = 0, exp_over = 0;

  task automatic send_frame(input int len, input int slot, input int gd, input int dd,
                            input logic [15:0] eth, input int abort_at);
    logic [7:0] fr[$];
    int idx, budget, b_wr, b_beats, b_fin, b_inv, b_desc, b_dv, b_req, b_viol, b_uns, mism, nw;
    bit aborted;
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    if (len > 13) begin
      fr[12] = eth[15:8];
      fr[13] = eth[7:0];
    end
    gnt_delay = gd;
    desc_delay = dd;
    gnt_slot = INDEX_SIZE'(slot);
    b_wr = wr_q.size(); b_beats = n_beats; b_fin = n_fin; b_inv = n_inv; b_desc = n_desc;
    b_dv = n_dvcyc; b_req = n_req; b_viol = n_viol; b_uns = n_unstable;
    idx = 0;
    aborted = 1'b0;
    budget = len * 4 + gd + 100;
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = fr[0]; bus.s_last = (len == 1);
    while (idx < len && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (bus.s_valid && beat_flag) begin
        idx++;
        if (idx == abort_at) begin
          reset = 1'b0;
          #1;
          chk("outs_in_midframe_reset", outs(), 0);
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
          repeat (2) @(posedge clk);
          @(negedge clk);
          reset = 1'b1;
          aborted = 1'b1;
          break;
        end
        if (idx < len && $urandom_range(0, 3) != 0) begin
          bus.s_data = fr[idx]; bus.s_last = (idx == len - 1);
        end else begin
          bus.s_valid = 1'b0; bus.s_last = 1'b0;
        end
      end else if (!bus.s_valid && idx < len) begin
        bus.s_valid = 1'b1; bus.s_data = fr[idx]; bus.s_last = (idx == len - 1);
      end
    end
    if (aborted) begin
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_invalidate", n_inv - b_inv, 0);
      chk("abort_no_finish", n_fin - b_fin, 0);
      return;
    end
    chk("src_bytes_accepted", idx, len);
    for (int i = 0; i < dd + 60; i++) begin
      @(posedge clk); #1;
      if (n_inv > b_inv || n_desc > b_desc) break;
    end
    repeat (2) @(posedge clk);
    #1;
    nw = (len > MAX_FRAME) ? MAX_FRAME : len;
    chk("wr_count", wr_q.size() - b_wr, nw);
    mism = 0;
    for (int i = 0; i < nw && b_wr + i < wr_q.size(); i++) if (wr_q[b_wr + i] !== fr[i]) mism++;
    chk("wr_data_mismatches", mism, 0);
    chk("beats_no_loss", n_beats - b_beats, len);
    chk("req_held_until_gnt", longint'((n_req - b_req) >= gd + 1), 1);
    chk("ready_while_alloc_or_desc", n_viol - b_viol, 0);
    if (len >= MIN_FRAME && len <= MAX_FRAME) begin
      exp_ok++;
      chk("finish_pulses", n_fin - b_fin, 1);
      chk("no_invalidate", n_inv - b_inv, 0);
      chk("desc_handshakes", n_desc - b_desc, 1);
      chk("desc_cycles", n_dvcyc - b_dv, dd + 1);
      chk("desc_slot", d_slot, slot);
      chk("desc_len", d_len, len);
      chk("desc_ethertype", d_eth, {fr[12], fr[13]});
      chk("desc_stable", n_unstable - b_uns, 0);
      chk("finish_latency", fin_cyc - last_cyc, 1);
      chk("desc_latency", dv_first_cyc - last_cyc, 2);
    end else begin
      if (len < MIN_FRAME) exp_runt++;
      else exp_over++;
      chk("no_finish", n_fin - b_fin, 0);
      chk("invalidate_pulses", n_inv - b_inv, 1);
      chk("inv_slot", inv_slot_seen, slot);
      chk("inv_latency", inv_cyc - last_cyc, 1);
      chk("no_desc_valid", n_dvcyc - b_dv, 0);
    end
`ifdef PRT_INGRESS_STATS_EN
    chk("stat_ok", stat_ok, exp_ok);
    chk("stat_runt", stat_runt, exp_runt);
    chk("stat_oversize", stat_oversize, exp_over);
`endif
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    #1;
    chk("outs_in_reset", outs(), 0);
`ifdef PRT_INGRESS_STATS_EN
    chk("stats_in_reset", {stat_ok, stat_runt, stat_oversize} != 0, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outs_after_reset", outs(), 0);

    send_frame(64, 2, 0, 0, 16'h0800, -1);
    send_frame(10, 1, 0, 0, 16'h0000, -1);
    send_frame(1530, 3, 0, 0, 16'h86dd, -1);
    send_frame(40, 0, 5, 0, 16'h0806, -1);
    send_frame(50, 2, 0, 20, 16'h88cc, -1);
    send_frame(64, 3, 0, 0, 16'h0800, 30);
    send_frame(64, 1, 1, 0, 16'h0800, -1);
    send_frame(13, 2, 0, 0, 16'h0000, -1);
    send_frame(14, 3, 0, 1, 16'h1234, -1);
    send_frame(1, 0, 0, 0, 16'h0000, -1);
    send_frame(1520, 1, 2, 0, 16'hbeef, -1);
    send_frame(1521, 2, 0, 0, 16'hcafe, -1);
    for (int i = 0; i < 6; i++)
      send_frame($urandom_range(1, 100), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 16'($urandom), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
